tone_meas: RTL and testbench

Receive-side measurement block for the DAC sample stream produced by the sine generators. It consumes the same two-samples-per-clock, 16-bit offset-binary format (s1 earlier, s2 later) and detects midscale rising crossings with hysteresis. Once per waveform period it reports the period length in samples and the peak, trough and peak-to-peak amplitude. It sits in the loopback/self-test path, between the generator (or ADC capture) and the status register file.

---
 rtl/tone_pkg.sv | 25 ++
 rtl/tone_meas_zc_pair.sv | 38 +++
 rtl/tone_meas.sv | 156 +++++++++++++++
 tb/tb_tone_meas.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared types and helpers for the tone measurement path.
// Sample format is 16-bit offset binary, two samples per clock.
package tone_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  typedef enum logic {
    SEEK,
    TRACK
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] ob2s(
    input logic [SAMPLE_W-1:0] x
  );
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

  function automatic logic [SAMPLE_W-1:0] s2ob(
    input logic signed [SAMPLE_W-1:0] x
  );
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/tone_meas_zc_pair.sv
// zc_pair: midscale rising-crossing detector with hysteresis.
// Evaluates s1 then s2; s2 sees the armed state left by s1.
module zc_pair
  import tone_pkg::*;
#(
  parameter int HYST = 4
) (
  input  logic                i_armed,
  input  logic [SAMPLE_W-1:0] i_s1,
  input  logic [SAMPLE_W-1:0] i_s2,
  output logic                o_hit,
  output logic                o_p,
  output logic                o_armed_next
);

  localparam logic signed [SAMPLE_W-1:0] W_TH = SAMPLE_W'(-HYST);

  logic signed [SAMPLE_W-1:0] w_a1;
  logic signed [SAMPLE_W-1:0] w_a2;
  logic w_hit1;
  logic w_hit2;
  logic w_arm1;

  assign w_a1 = ob2s(i_s1);
  assign w_a2 = ob2s(i_s2);

  assign w_hit1 = i_armed && (w_a1 >= 16'sd0);
  assign w_arm1 = w_hit1 ? 1'b0 :
                  (w_a1 <= W_TH) ? 1'b1 : i_armed;

  assign w_hit2 = w_arm1 && (w_a2 >= 16'sd0);
  assign o_armed_next = w_hit2 ? 1'b0 :
                        (w_a2 <= W_TH) ? 1'b1 : w_arm1;

  assign o_hit = w_hit1 | w_hit2;
  assign o_p   = w_hit2;

endmodule

// File: rtl/tone_meas.sv
// tone_meas: per-period length and amplitude measurement of a
// two-sample-per-clock offset-binary stream.
module tone_meas
  import tone_pkg::*;
#(
  parameter int MAX_PERIOD = 4000,
  parameter int MIN_PERIOD = 8,
  parameter int HYST       = 4,
  parameter int PW         = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] s1,
  input  logic [SAMPLE_W-1:0] s2,
  output logic                meas_valid,
  output logic [PW-1:0]       period,
  output logic [SAMPLE_W-1:0] vmax,
  output logic [SAMPLE_W-1:0] vmin,
  output logic [SAMPLE_W-1:0] pp,
  output logic                locked,
  output logic                err
);

  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_MAX = CW'(MAX_PERIOD);
  localparam logic [CW-1:0] C_MIN = CW'(MIN_PERIOD);
  localparam logic [CW-1:0] C_TWO = CW'(2);

  state_t                     r_state;
  logic                       r_armed;
  logic [CW-1:0]              r_cnt;
  logic signed [SAMPLE_W-1:0] r_emax;
  logic signed [SAMPLE_W-1:0] r_emin;

  logic                       w_hit;
  logic                       w_p;
  logic                       w_armed_nx;
  logic signed [SAMPLE_W-1:0] w_a1;
  logic signed [SAMPLE_W-1:0] w_a2;
  logic signed [SAMPLE_W-1:0] w_pmax;
  logic signed [SAMPLE_W-1:0] w_pmin;
  logic signed [SAMPLE_W-1:0] w_rmax;
  logic signed [SAMPLE_W-1:0] w_rmin;
  logic signed [SAMPLE_W-1:0] w_fmax;
  logic signed [SAMPLE_W-1:0] w_fmin;
  logic signed [SAMPLE_W-1:0] w_gmax;
  logic signed [SAMPLE_W-1:0] w_gmin;
  logic [SAMPLE_W-1:0]        w_fmax_ob;
  logic [SAMPLE_W-1:0]        w_fmin_ob;
  logic [CW-1:0]              w_cand;
  logic [CW-1:0]              w_cnt_rs;
  logic                       w_inrng;
  logic                       w_tout;

  zc_pair #(
    .HYST(HYST)
  ) u_zc (
    .i_armed     (r_armed),
    .i_s1        (s1),
    .i_s2        (s2),
    .o_hit       (w_hit),
    .o_p         (w_p),
    .o_armed_next(w_armed_nx)
  );

  assign w_a1 = ob2s(s1);
  assign w_a2 = ob2s(s2);

  assign w_pmax = (w_a1 > w_a2) ? w_a1 : w_a2;
  assign w_pmin = (w_a1 < w_a2) ? w_a1 : w_a2;

  // Extrema restart from the samples at or after the crossing.
  assign w_rmax = w_p ? w_a2 : w_pmax;
  assign w_rmin = w_p ? w_a2 : w_pmin;

  // Samples ahead of the crossing close out the old period.
  assign w_fmax = (w_p && (w_a1 > r_emax)) ? w_a1 : r_emax;
  assign w_fmin = (w_p && (w_a1 < r_emin)) ? w_a1 : r_emin;

  assign w_gmax = (w_pmax > r_emax) ? w_pmax : r_emax;
  assign w_gmin = (w_pmin < r_emin) ? w_pmin : r_emin;

  assign w_fmax_ob = s2ob(w_fmax);
  assign w_fmin_ob = s2ob(w_fmin);

  assign w_cand   = r_cnt + CW'(w_p);
  assign w_cnt_rs = C_TWO - CW'(w_p);
  assign w_inrng  = (w_cand >= C_MIN) && (w_cand <= C_MAX);
  assign w_tout   = (r_cnt + C_TWO) > C_MAX;

  // Crossing FSM, period counter, extrema and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEEK;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_emax     <= '0;
      r_emin     <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      period     <= '0;
      vmax       <= MIDSCALE;
      vmin       <= MIDSCALE;
      pp         <= '0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      if (in_valid) begin
        r_armed <= w_armed_nx;
        unique case (r_state)
          SEEK: begin
            if (w_hit) begin
              r_state <= TRACK;
              r_cnt   <= w_cnt_rs;
              r_emax  <= w_rmax;
              r_emin  <= w_rmin;
            end
          end
          TRACK: begin
            if (w_hit) begin
              if (w_inrng) begin
                meas_valid <= 1'b1;
                locked     <= 1'b1;
                period     <= w_cand[PW-1:0];
                vmax       <= w_fmax_ob;
                vmin       <= w_fmin_ob;
                pp         <= w_fmax_ob - w_fmin_ob;
              end else begin
                err    <= 1'b1;
                locked <= 1'b0;
              end
              r_cnt  <= w_cnt_rs;
              r_emax <= w_rmax;
              r_emin <= w_rmin;
            end else if (w_tout) begin
              err     <= 1'b1;
              locked  <= 1'b0;
              r_state <= SEEK;
              r_cnt   <= '0;
            end else begin
              r_cnt  <= r_cnt + C_TWO;
              r_emax <= w_gmax;
              r_emin <= w_gmin;
            end
          end
          default: begin
            r_state <= SEEK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_meas.sv
// tb_tone_meas: scoreboard bench for tone_meas.
// Stimulus queues expected reports; a monitor pops on each pulse.
module tb_tone_meas;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] s1 = 16'h8000;
  logic [15:0] s2 = 16'h8000;
  logic        meas_valid;
  logic [11:0] period;
  logic [15:0] vmax;
  logic [15:0] vmin;
  logic [15:0] pp;
  logic        locked;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [11:0] per;
    logic [15:0] mx;
    logic [15:0] mn;
    logic [15:0] pp;
    bit          lk;
  } exp_t;

  exp_t q[$];

  tone_meas #(
    .MAX_PERIOD(200),
    .MIN_PERIOD(8),
    .HYST(4),
    .PW(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .s1        (s1),
    .s2        (s2),
    .meas_valid(meas_valid),
    .period    (period),
    .vmax      (vmax),
    .vmin      (vmin),
    .pp        (pp),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_meas_valid"}, 32'(meas_valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_vmax"}, 32'(vmax), 32'h8000);
    chk({tag, "_vmin"}, 32'(vmin), 32'h8000);
    chk({tag, "_pp"}, 32'(pp), 0);
  endtask

  function automatic logic [15:0] sine(input int n, input int p);
    real x;
    int  v;
    x = 328.0 * $sin(6.283185307179586 * real'(n % p) / real'(p));
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return 16'(32768 + v);
  endfunction

  task automatic push(input bit is_err, input int p, input bit lk);
    exp_t e;
    e.is_err = is_err;
    e.cyc    = cyc + 1;
    e.per    = 12'(p);
    e.mx     = 16'h8148;
    e.mn     = 16'h7EB8;
    e.pp     = 16'h0290;
    e.lk     = lk;
    q.push_back(e);
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    s1 = a;
    s2 = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    s1 = 16'($urandom);
    s2 = 16'($urandom);
  endtask

  task automatic run_sine(input int p, input int n0, input int n1,
                          input int gap, input int meas_from);
    for (int n = n0; n <= n1; n += 2) begin
      while (gap > 0 && $urandom_range(99) < gap) idle_cycle();
      send_pair(sine(n, p), sine(n + 1, p));
      for (int k = 0; k < 2; k++)
        if (((n + k) % p) == 0 && (n + k) >= meas_from)
          push(1'b0, p, 1'b1);
    end
    idle_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every meas_valid/err pulse must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (meas_valid || err)) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: meas_valid=%0b err=%0b cyc=%0d",
                   meas_valid, err, cyc);
        end else begin
          e = q.pop_front();
          chk("pulse_kind_err", 32'(err), 32'(e.is_err));
          chk("pulse_kind_meas", 32'(meas_valid), 32'(!e.is_err));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          chk("period", 32'(period), 32'(e.per));
          chk("vmax", 32'(vmax), 32'(e.mx));
          chk("vmin", 32'(vmin), 32'(e.mn));
          chk("pp", 32'(pp), 32'(e.pp));
          chk("locked", 32'(locked), 32'(e.lk));
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Continuous 160-sample sine.
    run_sine(160, 0, 801, 0, 320);

    // Same stream with random bubbles.
    do_reset();
    run_sine(160, 0, 801, 30, 320);

    // 161-sample period: crossings alternate between s1 and s2.
    do_reset();
    run_sine(161, 0, 161 * 4 + 1, 0, 322);

    // Small noise around midscale never arms, then a sine.
    do_reset();
    for (int i = 0; i < 150; i++)
      send_pair(16'(32768 + int'($urandom_range(6)) - 3),
                16'(32768 + int'($urandom_range(6)) - 3));
    run_sine(160, 0, 481, 0, 320);

    // Lock, hold midscale until timeout, then relock.
    do_reset();
    run_sine(160, 0, 321, 0, 320);
    for (int j = 1; j <= 120; j++) begin
      send_pair(16'h8000, 16'h8000);
      if (j == 100) push(1'b1, 160, 1'b0);
    end
    idle_cycle();
    chk("locked_after_timeout", 32'(locked), 0);
    run_sine(160, 0, 321, 0, 320);

    // Asynchronous reset 90 samples into a period.
    do_reset();
    run_sine(160, 0, 409, 0, 320);
    chk("locked_before_rst", 32'(locked), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_sine(160, 412, 801, 0, 640);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
